pipe_datapath: RTL

Parametrised two-stage execute/writeback datapath that succeeds the single-cycle 8-bit datapath. It accepts pre-decoded instructions from the fetch/decode front end over a valid/ready handshake. It holds the register file, computes results with forwarding, and drives a wait-stated data-memory port with a req/ack handshake. Branch resolution and fetch stay upstream; this block only executes and retires in program order.

---
 rtl/pipe_datapath.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_datapath.sv
// Two-stage execute/writeback datapath. S1 reads operands (forwarded from the retiring
// instruction) and runs the ALU. S2 owns the data-memory access and retires in order.
module pipe_datapath #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RAW-1:0]    in_rs1,
  input  logic [RAW-1:0]    in_rs2,
  input  logic [RAW-1:0]    in_rd,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [2:0]        in_alu_op,
  input  logic              in_alu_src,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic [RAW-1:0]    wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam int SHW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SLT = 3'd7
  } alu_op_e;

  logic              s1_valid_q, s1_valid_d;
  logic [RAW-1:0]    s1_rs1_q, s1_rs1_d;
  logic [RAW-1:0]    s1_rs2_q, s1_rs2_d;
  logic [RAW-1:0]    s1_rd_q, s1_rd_d;
  logic [DATA_W-1:0] s1_imm_q, s1_imm_d;
  alu_op_e           s1_op_q, s1_op_d;
  logic              s1_src_q, s1_src_d;
  logic              s1_rw_q, s1_rw_d;
  logic              s1_mr_q, s1_mr_d;
  logic              s1_mw_q, s1_mw_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_res_q, s2_res_d;
  logic [DATA_W-1:0] s2_wdata_q, s2_wdata_d;
  logic [RAW-1:0]    s2_rd_q, s2_rd_d;
  logic              s2_rw_q, s2_rw_d;
  logic              s2_mr_q, s2_mr_d;
  logic              s2_mw_q, s2_mw_d;

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  logic              s2_mem, s2_done, s1_adv, in_fire, rf_we, fwd1, fwd2;
  logic [DATA_W-1:0] rs1_val, rs2_val, op_a, op_b, alu_res;
  logic [SHW-1:0]    shamt;

  assign s2_mem   = s2_mr_q || s2_mw_q;
  assign s2_done  = s2_valid_q && (!s2_mem || dmem_ack);
  assign s1_adv   = s1_valid_q && (!s2_valid_q || s2_done);
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  assign dmem_req   = s2_valid_q && s2_mem;
  assign dmem_we    = s2_mw_q;
  assign dmem_addr  = s2_res_q;
  assign dmem_wdata = s2_wdata_q;

  assign wb_valid = s2_done && (s2_rw_q || s2_mw_q);
  assign wb_rd    = s2_rd_q;

  // Stores report their data on the retire port; loads report the memory word.
  always_comb begin
    wb_data = s2_res_q;
    if (s2_mr_q) begin
      wb_data = dmem_rdata;
    end else if (s2_mw_q) begin
      wb_data = s2_wdata_q;
    end
  end

  assign rf_we = s2_done && s2_rw_q && (s2_rd_q != '0);
  assign fwd1  = rf_we && (s2_rd_q == s1_rs1_q);
  assign fwd2  = rf_we && (s2_rd_q == s1_rs2_q);

  assign rs1_val = fwd1 ? wb_data : rf_q[s1_rs1_q];
  assign rs2_val = fwd2 ? wb_data : rf_q[s1_rs2_q];
  assign op_a    = rs1_val;
  assign op_b    = s1_src_q ? s1_imm_q : rs2_val;
  assign shamt   = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (s1_op_q)
      OP_ADD: alu_res = op_a + op_b;
      OP_SUB: alu_res = op_a - op_b;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SLL: alu_res = op_a << shamt;
      OP_SRL: alu_res = op_a >> shamt;
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rs1_d   = s1_rs1_q;
    s1_rs2_d   = s1_rs2_q;
    s1_rd_d    = s1_rd_q;
    s1_imm_d   = s1_imm_q;
    s1_op_d    = s1_op_q;
    s1_src_d   = s1_src_q;
    s1_rw_d    = s1_rw_q;
    s1_mr_d    = s1_mr_q;
    s1_mw_d    = s1_mw_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_rs1_d   = in_rs1;
      s1_rs2_d   = in_rs2;
      s1_rd_d    = in_rd;
      s1_imm_d   = in_imm;
      s1_op_d    = alu_op_e'(in_alu_op);
      s1_src_d   = in_alu_src;
      s1_rw_d    = in_reg_write;
      s1_mr_d    = in_mem_read;
      s1_mw_d    = in_mem_write;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 keeps its payload after retiring so the memory port stays quiet but defined.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_wdata_d = s2_wdata_q;
    s2_rd_d    = s2_rd_q;
    s2_rw_d    = s2_rw_q;
    s2_mr_d    = s2_mr_q;
    s2_mw_d    = s2_mw_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_res_d   = alu_res;
      s2_wdata_d = rs2_val;
      s2_rd_d    = s1_rd_q;
      s2_rw_d    = s1_rw_q;
      s2_mr_d    = s1_mr_q;
      s2_mw_d    = s1_mw_q;
    end else if (s2_done) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (rf_we) begin
      rf_d[s2_rd_q] = wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_rd_q    <= '0;
      s1_imm_q   <= '0;
      s1_op_q    <= OP_ADD;
      s1_src_q   <= 1'b0;
      s1_rw_q    <= 1'b0;
      s1_mr_q    <= 1'b0;
      s1_mw_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_wdata_q <= '0;
      s2_rd_q    <= '0;
      s2_rw_q    <= 1'b0;
      s2_mr_q    <= 1'b0;
      s2_mw_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rs1_q   <= s1_rs1_d;
      s1_rs2_q   <= s1_rs2_d;
      s1_rd_q    <= s1_rd_d;
      s1_imm_q   <= s1_imm_d;
      s1_op_q    <= s1_op_d;
      s1_src_q   <= s1_src_d;
      s1_rw_q    <= s1_rw_d;
      s1_mr_q    <= s1_mr_d;
      s1_mw_q    <= s1_mw_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_wdata_q <= s2_wdata_d;
      s2_rd_q    <= s2_rd_d;
      s2_rw_q    <= s2_rw_d;
      s2_mr_q    <= s2_mr_d;
      s2_mw_q    <= s2_mw_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

endmodule
